jtag_stream_bridge: RTL
=======================

# jtag_stream_bridge

Parametrised JTAG user-data-register bridge sitting between the BSCANE2 user-chain signals and the puzzle logic inside `user_logic`. It frames each DR scan as one `DATA_WIDTH`-bit word plus a valid flag. Host→fabric words emerge as a one-cycle `rx_valid` strobe. Fabric→host results are buffered in a `DEPTH`-entry TX FIFO and returned on subsequent scans. Scans of the wrong length are rejected, and a TX word is only retired once its scan completes cleanly.

## Interface

Parameters:
- `DATA_WIDTH`, 8: payload bits per scan; DR length is `DR_LEN = DATA_WIDTH+1`.
- `DEPTH`, 4: TX FIFO entries; power of two, ≥2.

Ports:
- `tck`  in  1  sole clock, JTAG TCK.
- `test_logic_reset`  in  1  asynchronous, active-high reset.
- `ir_is_user`  in  1  IR selects this user chain; qualifies all TAP strobes.
- `capture_dr`  in  1  TAP in Capture-DR.
- `shift_dr`  in  1  TAP in Shift-DR.
- `update_dr`  in  1  TAP in Update-DR.
- `tdi`  in  1  serial data from host.
- `tdo`  out  1  serial data to host; equals `sr[0]`.
- `rx_valid`  out  1  one-cycle strobe; host word accepted.
- `rx_data`  out  `DATA_WIDTH`  host word; held until next accept.
- `tx_valid`  in  1  result word offered.
- `tx_data`  in  `DATA_WIDTH`  result word.
- `tx_ready`  out  1  FIFO can accept (`count < DEPTH`).
- `tx_level`  out  `$clog2(DEPTH)+1`  FIFO occupancy.

## Operation

- Shift register `sr[DR_LEN-1:0]`, LSB first.
  - `sr[DATA_WIDTH]` is the valid flag.
  - `sr[DATA_WIDTH-1:0]` is the payload.
- Capture (`ir_is_user & capture_dr`):
  - `sr <= {fifo_nonempty, fifo_nonempty ? head : 0}`.
  - `tx_pending <= fifo_nonempty`.
  - `bitcnt <= 0`.
  - No pop happens at capture.
- Shift (`ir_is_user & shift_dr`):
  - `sr <= {tdi, sr[DR_LEN-1:1]}`.
  - `bitcnt` increments, saturating at `DR_LEN+1`.
- Update (`ir_is_user & update_dr`): the frame is good iff `bitcnt == DR_LEN`.
  - Good frame with `tx_pending`: pop the FIFO head.
  - Good frame with `sr[DATA_WIDTH]==1`: `rx_valid` pulses and `rx_data <= sr[DATA_WIDTH-1:0]`.
  - Good frame with flag 0: poll only; no `rx_valid`.
  - Bad frame (short or long): no pop, no `rx_valid`. The same head is re-presented at the next capture.
  - `tx_pending` clears on every update.
- TAP strobes seen while `ir_is_user==0` are ignored; `sr`, `bitcnt` and `tx_pending` hold.
- TX FIFO:
  - Circular buffer with read/write pointers of `$clog2(DEPTH)` bits (wrap naturally) and `count` of `$clog2(DEPTH)+1` bits.
  - Push when `tx_valid & tx_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - At full, `tx_ready=0` even in a pop cycle (pre-cycle count governs).
- Reset (asynchronous, any time including mid-scan): clears `sr`, `bitcnt`, `tx_pending`, pointers, `count` and `rx_data`. The FIFO contents are discarded.

## Timing

- Reset values:
  - `tdo=0`, `rx_valid=0`, `rx_data=0`.
  - `tx_ready=1`, `tx_level=0`.
- All state updates on the rising edge of `tck`.
- `tdo` is registered (`sr[0]`) and is valid for the host's falling-edge sample.
- `rx_valid` rises on the edge where `update_dr` is sampled high, stays high exactly one cycle, and is never asserted in back-to-back cycles.
- `tx_ready` and `tx_level` are combinational from `count`.
  - A push is visible in `tx_level` one cycle later.
  - A pushed word is presentable at the first capture after the push edge.
- Push-to-host latency is at least one complete scan; with k words queued ahead, it is k+1 good scans.

## Configuration

- Macro: `JTAG_STREAM_BRIDGE_LOOPBACK_EN`.
- Defined:
  - Every good frame with flag 1 is also pushed into the TX FIFO at the update edge, alongside `rx_valid`.
  - The external `tx_valid`/`tx_data` inputs are ignored and `tx_ready` is held 0.
  - The loopback push is dropped if pre-cycle `count == DEPTH`.
  - Loopback push and pop in the same update cycle are both honoured.
- Undefined: normal operation as above; loopback logic is absent.

## Test plan

All scenarios use `DATA_WIDTH=8`, `DEPTH=4`.

- Reset then one 9-bit scan, host shifts flag=1, data=0xA5 → `rx_valid` for 1 cycle with `rx_data=0xA5`; `tdo` stream reads 0x000 (flag 0, FIFO empty).
- Push 0x11, 0x22; run two 9-bit poll scans (flag 0) → host reads {1,0x11}, then {1,0x22}; `tx_level` goes 2→1→0; no `rx_valid` pulses.
- Push 5 words 0x01..0x05 back-to-back → `tx_ready` drops after the 4th; 0x05 is held by the source; `tx_level=4`.
- Queue 0x33; run an 8-bit scan, then a 10-bit scan, then a 9-bit scan → 0x33 is presented on all three; only the 9-bit scan pops it; no `rx_valid` on the bad scans.
- Assert `test_logic_reset` mid-shift with 2 words queued → on release `tx_level=0`, `tx_ready=1`, `tdo=0`; the next scan reads flag 0.
- With `JTAG_STREAM_BRIDGE_LOOPBACK_EN` defined: scan in 0x5A (flag 1), then scan flag 0 → second scan returns {1,0x5A}.

Source files
------------

// File: rtl/jtag_stream_bridge.sv
// jtag_stream_bridge
//   Frames each user-chain DR scan as a DATA_WIDTH-bit payload plus a valid
//   flag (MSB of the DR). Host words that arrive in a correctly sized scan
//   with the flag set are emitted as a one-cycle rx_valid strobe. Fabric
//   results are queued in a DEPTH-entry FIFO and returned on later scans.
//   The FIFO head is popped only when the scan that carried it ends with
//   exactly DR_LEN shift cycles.
//
//   Optional build macro: JTAG_STREAM_BRIDGE_LOOPBACK_EN
//     When defined, every accepted host word is pushed back into the TX
//     FIFO, and the external tx_valid/tx_data inputs are ignored.
//
// Ports
//   tck, test_logic_reset     clock / async active-high reset
//   ir_is_user                qualifies capture_dr, shift_dr, update_dr
//   tdi, tdo                  serial in / registered serial out (sr[0])
//   rx_valid, rx_data         accepted host word (strobe / held data)
//   tx_valid, tx_data         result word offer from fabric
//   tx_ready, tx_level        FIFO not full / FIFO occupancy
module jtag_stream_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       tck,
  input  logic                       test_logic_reset,
  input  logic                       ir_is_user,
  input  logic                       capture_dr,
  input  logic                       shift_dr,
  input  logic                       update_dr,
  input  logic                       tdi,
  output logic                       tdo,
  output logic                       rx_valid,
  output logic [DATA_WIDTH-1:0]      rx_data,
  input  logic                       tx_valid,
  input  logic [DATA_WIDTH-1:0]      tx_data,
  output logic                       tx_ready,
  output logic [$clog2(DEPTH):0]     tx_level
);

  localparam int DR_LEN = DATA_WIDTH + 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BC_W   = $clog2(DR_LEN + 2);
  localparam logic [BC_W-1:0]  BC_GOOD = BC_W'(DR_LEN);
  localparam logic [BC_W-1:0]  BC_MAX  = BC_W'(DR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DR_LEN-1:0]     sr;
  logic [BC_W-1:0]       bitcnt;
  logic                  tx_pending;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [CNT_W-1:0]      count;

  logic                  cap, shf, upd, frame_good;
  logic                  rx_fire, pop, push, full, nonempty;
  logic [DATA_WIDTH-1:0] head, wdata;

  // TAP strobes are treated as mutually exclusive; capture wins, then shift.
  assign cap        = ir_is_user & capture_dr;
  assign shf        = ir_is_user & shift_dr & ~capture_dr;
  assign upd        = ir_is_user & update_dr & ~capture_dr & ~shift_dr;
  assign frame_good = upd & (bitcnt == BC_GOOD);

  assign full     = (count == CNT_FULL);
  assign nonempty = (count != '0);
  assign head     = mem[rd_ptr];

  // Gating with rx_valid keeps the strobe from repeating if update_dr is
  // ever held for more than one cycle.
  assign rx_fire = frame_good & sr[DATA_WIDTH] & ~rx_valid;
  assign pop     = frame_good & tx_pending;

`ifdef JTAG_STREAM_BRIDGE_LOOPBACK_EN
  logic unused_tx_inputs;
  assign unused_tx_inputs = ^{tx_valid, tx_data};
  assign push     = rx_fire & ~full;
  assign wdata    = sr[DATA_WIDTH-1:0];
  assign tx_ready = 1'b0;
`else
  assign push     = tx_valid & ~full;
  assign wdata    = tx_data;
  assign tx_ready = ~full;
`endif

  assign tx_level = count;
  assign tdo      = sr[0];

  // Scan framing and host-word acceptance
  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      sr         <= '0;
      bitcnt     <= '0;
      tx_pending <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
    end else begin
      rx_valid <= rx_fire;
      if (rx_fire) rx_data <= sr[DATA_WIDTH-1:0];
      if (cap) begin
        sr         <= nonempty ? {1'b1, head} : '0;
        tx_pending <= nonempty;
        bitcnt     <= '0;
      end else if (shf) begin
        sr <= {tdi, sr[DR_LEN-1:1]};
        if (bitcnt != BC_MAX) bitcnt <= bitcnt + BC_W'(1);
      end else if (upd) begin
        tx_pending <= 1'b0;
      end
    end
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge tck or posedge test_logic_reset) begin
    if (test_logic_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge tck) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule
